// File: rtl/slice_line_responder_pkg.sv
// Shared definitions for the slice-processing responder and its controller.
// Holds the FSM encoding and the default block geometry.
package slice_line_responder_pkg;
  localparam int SLR_W     = 25;
  localparam int SLR_LINES = 25;
  localparam int SLR_CW    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SERVE = 2'd2,
    DRAIN = 2'd3
  } state_t;
endpackage

// File: rtl/slice_line_responder_if.sv
// Bundle of load stream, controller read/write-back, and drain stream signals.
// Streams: a word moves on a clock edge where valid and ready are both high; valid does not wait on ready.
interface slice_line_responder_if
  import slice_line_responder_pkg::*;
#(
  parameter int W  = SLR_W,
  parameter int CW = SLR_CW
);
  logic          load_valid;
  logic [W-1:0]  load_data;
  logic          load_ready;
  logic          rd_req;
  logic [W-1:0]  line;
  logic          line_valid;
  logic [CW-1:0] count;
  logic          wr_req;
  logic [W-1:0]  wr_data;
  logic          done;
  logic          drain_valid;
  logic [W-1:0]  drain_data;
  logic          drain_ready;
  logic          busy;
  logic          rd_err;

  modport slave (
    input  load_valid, load_data, rd_req, wr_req, wr_data, drain_ready,
    output load_ready, line, line_valid, count, done, drain_valid, drain_data,
           busy, rd_err
  );

  modport master (
    output load_valid, load_data, rd_req, wr_req, wr_data, drain_ready,
    input  load_ready, line, line_valid, count, done, drain_valid, drain_data,
           busy, rd_err
  );
endinterface

// File: rtl/slice_line_responder_line_regfile.sv
// LINES x W line storage: one synchronous write port, two combinational read ports.
module line_regfile #(
  parameter int W     = 25,
  parameter int LINES = 25,
  parameter int CW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [CW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [CW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);
  logic [W-1:0] mem [LINES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LINES; i++) begin
      if (we && waddr == CW'(i)) mem[i] <= wdata;
    end
  end

  // Address decode by compare keeps out-of-range pointers reading zero.
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < LINES; i++) begin
      if (raddr_a == CW'(i)) rdata_a = mem[i];
      if (raddr_b == CW'(i)) rdata_b = mem[i];
    end
  end
endmodule

// File: rtl/slice_line_responder.sv
// Block buffer between load/drain streams and the slice controller.
// Fills a block, serves line reads and write-backs, then drains the processed block.
module slice_line_responder
  import slice_line_responder_pkg::*;
#(
  parameter int W     = SLR_W,
  parameter int LINES = SLR_LINES,
  parameter int CW    = SLR_CW
) (
  input  logic                   clk,
  input  logic                   rst,
  slice_line_responder_if.slave  bus,
  output state_t                 dbg_state
);
  state_t        state, state_nx;
  logic [CW-1:0] wptr, rptr, dptr, count_q;
  logic          load_fire, rd_fire, rd_bad, wr_fire, drain_fire;
  logic          we;
  logic [CW-1:0] waddr;
  logic [W-1:0]  wdata, rd_line, dr_line, line_q;
  logic          line_valid_q, done_q, rd_err_q;

  line_regfile #(.W(W), .LINES(LINES), .CW(CW)) u_regfile (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rptr),
    .rdata_a (rd_line),
    .raddr_b (dptr),
    .rdata_b (dr_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    load_fire  = 1'b0;
    rd_fire    = 1'b0;
    rd_bad     = 1'b0;
    wr_fire    = 1'b0;
    drain_fire = 1'b0;
    we         = 1'b0;
    waddr      = wptr;
    wdata      = bus.load_data;
    case (state)
      IDLE: begin
        load_fire = bus.load_valid;
        we        = load_fire;
        waddr     = '0;
        rd_bad    = bus.rd_req;
        if (load_fire) state_nx = FILL;
      end
      FILL: begin
        load_fire = bus.load_valid;
        we        = load_fire;
        rd_bad    = bus.rd_req;
        if (load_fire && wptr == CW'(LINES - 1)) state_nx = SERVE;
      end
      SERVE: begin
        rd_fire = bus.rd_req && (rptr < CW'(LINES));
        rd_bad  = bus.rd_req && !(rptr < CW'(LINES));
        wr_fire = bus.wr_req && (wptr < CW'(LINES));
        we      = wr_fire;
        wdata   = bus.wr_data;
        if (wr_fire && wptr == CW'(LINES - 1)) state_nx = DRAIN;
      end
      DRAIN: begin
        drain_fire = bus.drain_ready;
        rd_bad     = bus.rd_req;
        if (drain_fire && dptr == CW'(LINES - 1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read data comes from the pre-edge register contents, so a same-address
  // write in the same cycle is not visible to the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      dptr         <= '0;
      count_q      <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      line_valid_q <= rd_fire;
      done_q       <= 1'b0;
      if (rd_bad) rd_err_q <= 1'b1;
      case (state)
        IDLE: if (load_fire) begin
          wptr     <= CW'(1);
          rd_err_q <= 1'b0;
        end
        FILL: if (load_fire) begin
          if (wptr == CW'(LINES - 1)) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
          end else begin
            wptr <= wptr + CW'(1);
          end
        end
        SERVE: begin
          if (rd_fire) begin
            line_q  <= rd_line;
            rptr    <= rptr + CW'(1);
            count_q <= count_q + CW'(1);
          end
          if (wr_fire) begin
            if (wptr == CW'(LINES - 1)) begin
              wptr   <= '0;
              dptr   <= '0;
              done_q <= 1'b1;
            end else begin
              wptr <= wptr + CW'(1);
            end
          end
        end
        DRAIN: if (drain_fire) begin
          if (dptr == CW'(LINES - 1)) dptr <= '0;
          else                        dptr <= dptr + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready  = (state == IDLE) || (state == FILL);
  assign bus.line        = line_q;
  assign bus.line_valid  = line_valid_q;
  assign bus.count       = count_q;
  assign bus.done        = done_q;
  assign bus.drain_valid = (state == DRAIN);
  assign bus.drain_data  = dr_line;
  assign bus.busy        = (state != IDLE);
  assign bus.rd_err      = rd_err_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_slice_line_responder.sv
// Directed bench for slice_line_responder: fill, serve, write-back, drain, reset mid-block.
module tb_slice_line_responder;
  import slice_line_responder_pkg::*;

  localparam int W     = 25;
  localparam int LINES = 25;
  localparam int CW    = 6;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  slice_line_responder_if #(.W(W), .CW(CW)) bus ();

  slice_line_responder #(.W(W), .LINES(LINES), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] load_m [LINES];
  int wptr_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic fill_block(input logic [W-1:0] base, input int gap_at);
    for (int i = 0; i < LINES; i++) begin
      if (i == gap_at) begin
        bus.load_valid = 1'b0;
        bus.rd_req     = 1'b1;
        for (int g = 0; g < 3; g++) begin
          step();
          bus.rd_req = 1'b0;
          chk("fill_gap_state", 32'(dbg_state), 32'(FILL));
          chk("fill_gap_ready", 32'(bus.load_ready), 32'd1);
        end
        chk("rd_err_in_fill", 32'(bus.rd_err), 32'd1);
      end
      bus.load_valid = 1'b1;
      bus.load_data  = base + W'(i);
      load_m[i]      = base + W'(i);
      step();
      if (i == 0) chk("rd_err_clr_on_fill", 32'(bus.rd_err), 32'd0);
      chk("fill_state", 32'(dbg_state), (i == LINES - 1) ? 32'(SERVE) : 32'(FILL));
    end
    bus.load_valid = 1'b0;
    chk("serve_load_ready", 32'(bus.load_ready), 32'd0);
    chk("serve_count0", 32'(bus.count), 32'd0);
    wptr_m = 0;
  endtask

  task automatic do_reads(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      bus.rd_req = 1'b1;
      step();
      bus.rd_req = 1'b0;
      chk("rd_valid", 32'(bus.line_valid), 32'd1);
      chk("rd_line", 32'(bus.line), 32'(load_m[i]));
      chk("rd_count", 32'(bus.count), 32'(i + 1));
    end
  endtask

  task automatic do_writes(input int n, input logic [W-1:0] base);
    logic [W-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = base + W'(wptr_m);
      bus.wr_req  = 1'b1;
      bus.wr_data = d;
      exp_q.push_back(d);
      wptr_m++;
      step();
      bus.wr_req = 1'b0;
      chk("wr_done", 32'(bus.done), (wptr_m == LINES) ? 32'd1 : 32'd0);
      chk("wr_state", 32'(dbg_state), (wptr_m == LINES) ? 32'(DRAIN) : 32'(SERVE));
    end
    chk("drain_valid_rise", 32'(bus.drain_valid), 32'd1);
  endtask

  // scoreboard: drained words are popped against exp_q
  task automatic drain_block(input bit toggle);
    logic [W-1:0] e;
    for (int j = 0; j < LINES; j++) begin
      e = exp_q.pop_front();
      chk("drain_valid", 32'(bus.drain_valid), 32'd1);
      chk("drain_data", 32'(bus.drain_data), 32'(e));
      if (toggle) begin
        bus.drain_ready = 1'b0;
        step();
        if (j == 0) chk("done_pulse_end", 32'(bus.done), 32'd0);
        chk("drain_hold", 32'(bus.drain_data), 32'(e));
      end
      bus.drain_ready = 1'b1;
      step();
      bus.drain_ready = 1'b0;
      if (j == 0 && !toggle) chk("done_pulse_end", 32'(bus.done), 32'd0);
    end
    chk("drain_idle", 32'(dbg_state), 32'(IDLE));
    chk("drain_load_ready", 32'(bus.load_ready), 32'd1);
    chk("drain_busy", 32'(bus.busy), 32'd0);
    chk("drain_valid_off", 32'(bus.drain_valid), 32'd0);
    chk("drain_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_data   = '0;
    bus.rd_req      = 1'b0;
    bus.wr_req      = 1'b0;
    bus.wr_data     = '0;
    bus.drain_ready = 1'b0;
    step();
    step();
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_line", 32'(bus.line), 32'd0);
    chk("rst_line_valid", 32'(bus.line_valid), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_rd_err", 32'(bus.rd_err), 32'd0);
    chk("rst_drain_valid", 32'(bus.drain_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_load_ready", 32'(bus.load_ready), 32'd1);
    rst = 1'b0;
    step();

    // Block 1: lines 1..25, read-before-write at address 0, overrun read, toggled drain
    fill_block(W'(1), -1);
    bus.rd_req  = 1'b1;
    bus.wr_req  = 1'b1;
    bus.wr_data = W'(25'h1FFFFFF);
    step();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    exp_q.push_back(W'(25'h1FFFFFF));
    wptr_m = 1;
    chk("rbw_valid", 32'(bus.line_valid), 32'd1);
    chk("rbw_line_old", 32'(bus.line), 32'h1);
    chk("rbw_count", 32'(bus.count), 32'd1);
    do_reads(1, LINES - 1);
    chk("final_count", 32'(bus.count), 32'd25);
    chk("last_line", 32'(bus.line), 32'h19);
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    chk("overrun_no_valid", 32'(bus.line_valid), 32'd0);
    chk("overrun_rd_err", 32'(bus.rd_err), 32'd1);
    chk("overrun_count", 32'(bus.count), 32'd25);
    do_writes(LINES - 1, W'(25'h100000));
    drain_block(1'b1);
    chk("rd_err_sticky", 32'(bus.rd_err), 32'd1);

    // Block 2: fill with a 3-cycle gap, then reset in SERVE after 10 reads
    fill_block(W'(25'h100), 10);
    do_reads(0, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(bus.count), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_line_valid", 32'(bus.line_valid), 32'd0);
    chk("arst_load_ready", 32'(bus.load_ready), 32'd1);
    chk("arst_state", 32'(dbg_state), 32'(IDLE));
    chk("arst_rd_err", 32'(bus.rd_err), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Block 3: full normal block after reset, drain never stalls
    fill_block(W'(25'h0A0000), -1);
    do_reads(0, LINES);
    do_writes(LINES, W'(25'h1500000));
    drain_block(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
